// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and state encoding for the instruction fetch stage.
package if_stage_pkg;

    localparam logic [31:0] IF_NOP_INSTR = 32'h00000013;
    localparam int          PC_INC       = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// if_stage: fetch stage owning the fetch PC; one outstanding imem request,
// a one-entry hold buffer for stalls and flush-on-redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                    WORD_SIZE = 32,
    parameter int                    ADDR_SIZE = 10,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0]  NOP_INSTR = IF_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [ADDR_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid
);

    if_state_e            r_state, w_next;
    logic                 r_req, r_valid;
    logic [ADDR_SIZE-1:0] r_fetch_pc, r_req_pc, r_hold_pc, r_pc;
    logic [WORD_SIZE-1:0] r_hold_instr, r_instr;
    logic                 w_accept, w_rsp, w_take_hold, w_load_rsp, w_load_hold;

    assign w_accept    = (r_state == FETCH) && r_req && imem_ready;
    assign w_rsp       = (r_state == WAIT) && imem_rvalid;
    assign w_take_hold = w_rsp && stall && !redirect;
    assign w_load_rsp  = w_rsp && !stall && !redirect;
    assign w_load_hold = (r_state == HOLD) && !stall && !redirect;

    // A redirect with a request still in flight must swallow its response in DROP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   w_next = w_accept ? (redirect ? DROP : WAIT) : FETCH;
            WAIT:    w_next = imem_rvalid ? (w_take_hold ? HOLD : FETCH) : (redirect ? DROP : WAIT);
            HOLD:    w_next = (stall && !redirect) ? HOLD : FETCH;
            default: w_next = imem_rvalid ? FETCH : DROP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH;
            r_req        <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_hold_pc    <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == FETCH);
            if (redirect)
                r_fetch_pc <= {redirect_pc[ADDR_SIZE-1:2], 2'b00};
            else if (w_accept)
                r_fetch_pc <= r_fetch_pc + ADDR_SIZE'(PC_INC);
            if (w_accept)
                r_req_pc <= r_fetch_pc;
            if (w_take_hold) begin
                r_hold_pc    <= r_req_pc;
                r_hold_instr <= imem_rdata;
            end
            if (redirect || !stall) begin
                r_pc    <= w_load_rsp ? r_req_pc : w_load_hold ? r_hold_pc : r_pc;
                r_instr <= w_load_rsp ? imem_rdata : w_load_hold ? r_hold_instr : NOP_INSTR;
                r_valid <= w_load_rsp || w_load_hold;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_fetch_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios for if_stage with a scoreboard on
// accepted imem requests and delivered instructions.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, instr_valid;
    logic [9:0]  imem_addr, pc;
    logic [31:0] instr;

    int          compared = 0, mismatched = 0, lat = 1;
    logic [31:0] mem [256];
    logic [9:0]  exp_addr [$];
    logic [41:0] exp_out [$];

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .instr(instr), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Instruction memory: responds lat cycles after an accepted request.
    initial begin
        int         cnt;
        logic [9:0] pa, a;
        logic       hit;
        cnt = 0;
        pa  = '0;
        forever begin
            @(posedge clk);
            hit = rst && imem_req && imem_ready;
            a   = imem_addr;
            #1;
            if (!rst) begin
                cnt = 0;
                imem_rvalid = 1'b0;
            end else begin
                if (hit) begin
                    pa  = a;
                    cnt = lat;
                end
                imem_rvalid = (cnt == 1);
                if (cnt == 1) imem_rdata = mem[pa[9:2]];
                if (cnt > 0) cnt--;
            end
        end
    end

    // Monitor: checks accepted requests and freshly loaded instructions.
    initial begin
        logic       st, rd, acc;
        logic [9:0] a;
        forever begin
            @(posedge clk);
            st  = stall;
            rd  = redirect;
            acc = rst && imem_req && imem_ready;
            a   = imem_addr;
            if (acc) begin
                if (exp_addr.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_req: got addr %h, expected no request", a);
                end else chk("req_addr", 42'(a), 42'(exp_addr.pop_front()));
            end
            @(negedge clk);
            if (rst && instr_valid && !st && !rd) begin
                if (exp_out.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out: got pc %h instr %h, expected none", pc, instr);
                end else chk("out_pc_instr", {pc, instr}, exp_out.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h00ee8c33;
        mem[8'h01] = 32'h400bd633;
        mem[8'h02] = 32'h00eb9013;
        mem[8'h03] = 32'hed071e23;
        mem[8'h4c] = 32'hdeadbeef;
        mem[8'hff] = 32'h00100093;

        repeat (2) @(negedge clk);
        chk("rst_pc", 42'(pc), 42'h000);
        chk("rst_instr", 42'(instr), 42'(IF_NOP_INSTR));
        chk("rst_valid", 42'(instr_valid), 42'h0);
        chk("rst_req", 42'(imem_req), 42'h0);

        // Back-to-back fetches with 1-cycle memory.
        exp_addr.push_back(10'h000);
        exp_addr.push_back(10'h004);
        exp_out.push_back({10'h000, 32'h00ee8c33});
        exp_out.push_back({10'h004, 32'h400bd633});
        rst = 1'b1;
        imem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("s1_valid", 42'(instr_valid), 42'h1);

        // Memory not ready for 3 cycles.
        imem_ready = 1'b0;
        exp_addr.push_back(10'h008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nrdy_req", 42'(imem_req), 42'h1);
            chk("nrdy_addr", 42'(imem_addr), 42'h008);
            chk("nrdy_valid", 42'(instr_valid), 42'h0);
            chk("nrdy_instr", 42'(instr), 42'(IF_NOP_INSTR));
        end
        imem_ready = 1'b1;
        exp_out.push_back({10'h008, 32'h00eb9013});

        // Stall as the response arrives; release after 2 cycles.
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_valid", 42'(instr_valid), 42'h0);
            chk("stall_pc", 42'(pc), 42'h004);
            chk("stall_req", 42'(imem_req), 42'h0);
        end
        stall = 1'b0;
        exp_addr.push_back(10'h00c);
        @(negedge clk);
        chk("unstall_valid", 42'(instr_valid), 42'h1);
        chk("unstall_addr", 42'(imem_addr), 42'h00c);
        chk("unstall_req", 42'(imem_req), 42'h1);
        lat = 2;

        // Redirect while waiting on a 2-cycle response.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 10'h133;
        exp_addr.push_back(10'h130);
        @(negedge clk);
        chk("drop_valid", 42'(instr_valid), 42'h0);
        chk("drop_req", 42'(imem_req), 42'h0);
        redirect = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("redir_req", 42'(imem_req), 42'h1);
        chk("redir_addr", 42'(imem_addr), 42'h130);
        chk("redir_valid", 42'(instr_valid), 42'h0);
        chk("redir_instr", 42'(instr), 42'(IF_NOP_INSTR));

        // Redirect with stall and a full hold buffer; wrap at top of space.
        @(negedge clk);
        stall = 1'b1;
        exp_addr.push_back(10'h3fc);
        @(negedge clk);
        chk("hold_req", 42'(imem_req), 42'h0);
        redirect = 1'b1;
        redirect_pc = 10'h3fc;
        @(negedge clk);
        chk("flush_valid", 42'(instr_valid), 42'h0);
        chk("flush_instr", 42'(instr), 42'(IF_NOP_INSTR));
        chk("flush_req", 42'(imem_req), 42'h1);
        chk("flush_addr", 42'(imem_addr), 42'h3fc);
        redirect = 1'b0;
        stall = 1'b0;
        exp_out.push_back({10'h3fc, 32'h00100093});
        exp_addr.push_back(10'h000);
        repeat (2) @(negedge clk);
        chk("wrap_addr", 42'(imem_addr), 42'h000);
        chk("wrap_req", 42'(imem_req), 42'h1);
        chk("wrap_valid", 42'(instr_valid), 42'h1);

        // Reset asserted while a request is outstanding.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_pc", 42'(pc), 42'h000);
        chk("mid_rst_instr", 42'(instr), 42'(IF_NOP_INSTR));
        chk("mid_rst_valid", 42'(instr_valid), 42'h0);
        chk("mid_rst_req", 42'(imem_req), 42'h0);
        @(negedge clk);
        exp_addr.push_back(10'h000);
        exp_out.push_back({10'h000, 32'h00ee8c33});
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 42'(instr_valid), 42'h1);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("addr_left", 42'(exp_addr.size()), 42'h0);
        chk("out_left", 42'(exp_out.size()), 42'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
